dec_to_bcd_key_encoder_v: RTL and testbench

Synchronous decimal-to-BCD key encoder, the inverse of the team's BCD-to-decimal decoder. It samples ten active-low decimal lines from a keypad or switch bank and synchronizes and debounces them. It priority-encodes the highest active line to a 4-bit BCD code on a/b/c/d, matching the decoder's input weighting, and presents each press exactly once through a valid/ready handshake. It sits between raw front-panel inputs and the datapath that consumes BCD digits.

---
 rtl/dec_to_bcd_key_encoder_v.sv | 179 +++++++++++++++++
 tb/tb_dec_to_bcd_key_encoder_v.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dec_to_bcd_key_encoder_v.sv
// Decimal keypad to BCD encoder: synchronizes and debounces ten active-low key
// lines, priority-encodes the highest active key and hands each press out once.
module dec_to_bcd_key_encoder_v #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_n_rst,
  input  logic i_n_0,
  input  logic i_n_1,
  input  logic i_n_2,
  input  logic i_n_3,
  input  logic i_n_4,
  input  logic i_n_5,
  input  logic i_n_6,
  input  logic i_n_7,
  input  logic i_n_8,
  input  logic i_n_9,
  input  logic i_ready,
  output logic o_a,
  output logic o_b,
  output logic o_c,
  output logic o_d,
  output logic o_valid,
  output logic o_multi
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESENT,
    WAIT_RELEASE
  } state_t;

  logic [9:0] n_raw;
  logic [9:0] n_meta;
  logic [9:0] n_sync;
  logic [9:0] active;

  assign n_raw = {i_n_9, i_n_8, i_n_7, i_n_6, i_n_5,
                  i_n_4, i_n_3, i_n_2, i_n_1, i_n_0};

  // Synchronizer flops reset to 1 so a reset never looks like a key press.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which keeps the two stages distinct.
  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      n_meta <= '1;
      n_sync <= '1;
    end else begin
      n_meta <= n_raw;
      n_sync <= n_meta;
    end
  end

  assign active = ~n_sync;

  logic [3:0] enc_code;
  logic       enc_any;
  logic       enc_multi;

  // Ascending scan: the last active index seen is the highest, so it wins.
  // NOTE: every always_comb output gets a default first; a path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    enc_code  = '0;
    enc_any   = 1'b0;
    enc_multi = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (active[i]) begin
        if (enc_any) enc_multi = 1'b1;
        enc_any  = 1'b1;
        enc_code = 4'(i);
      end
    end
  end

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [CW-1:0] rcnt_q, rcnt_n;
  logic [3:0]    cand_q, cand_n;
  logic [3:0]    code_q, code_n;
  logic          multi_q, multi_n;
  logic          valid_q, valid_n;

  always_ff @(posedge i_clk or negedge i_n_rst) begin
    if (!i_n_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      multi_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      rcnt_q  <= rcnt_n;
      cand_q  <= cand_n;
      code_q  <= code_n;
      multi_q <= multi_n;
      valid_q <= valid_n;
    end
  end

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    rcnt_n  = rcnt_q;
    cand_n  = cand_q;
    code_n  = code_q;
    multi_n = multi_q;
    valid_n = valid_q;

    unique case (state_q)
      IDLE: begin
        if (enc_any) begin
          cand_n  = enc_code;
          cnt_n   = CW'(1);
          rcnt_n  = '0;
          state_n = DEBOUNCE;
        end
      end

      DEBOUNCE: begin
        if (enc_any && (enc_code == cand_q)) begin
          if (cnt_q == CNT_LAST) begin
            code_n  = cand_q;
            multi_n = enc_multi;
            valid_n = 1'b1;
            cnt_n   = '0;
            state_n = PRESENT;
          end else begin
            cnt_n = cnt_q + 1'b1;
          end
        end else begin
          // Bounce, release or a different key: start over silently.
          cnt_n   = '0;
          state_n = IDLE;
        end
      end

      PRESENT: begin
        // Key activity is ignored here; only the consumer can end the present.
        if (i_ready) begin
          valid_n = 1'b0;
          rcnt_n  = '0;
          state_n = WAIT_RELEASE;
        end
      end

      WAIT_RELEASE: begin
        if (enc_any) begin
          rcnt_n = '0;
        end else if (rcnt_q == CNT_LAST) begin
          rcnt_n  = '0;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          rcnt_n = rcnt_q + 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign o_a     = code_q[0];
  assign o_b     = code_q[1];
  assign o_c     = code_q[2];
  assign o_d     = code_q[3];
  assign o_multi = multi_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_dec_to_bcd_key_encoder_v.sv
// Directed bench for dec_to_bcd_key_encoder_v at DEBOUNCE_CYCLES = 4.
module tb_dec_to_bcd_key_encoder_v;

  logic       i_clk = 1'b0;
  logic       i_n_rst;
  logic [9:0] n_key;
  logic       i_ready;
  logic       o_a, o_b, o_c, o_d, o_valid, o_multi;
  logic [3:0] code;

  int total  = 0;
  int passed = 0;

  always #5 i_clk = ~i_clk;

  assign code = {o_d, o_c, o_b, o_a};

  dec_to_bcd_key_encoder_v #(.DEBOUNCE_CYCLES(4)) dut (
    .i_clk   (i_clk),
    .i_n_rst (i_n_rst),
    .i_n_0   (n_key[0]),
    .i_n_1   (n_key[1]),
    .i_n_2   (n_key[2]),
    .i_n_3   (n_key[3]),
    .i_n_4   (n_key[4]),
    .i_n_5   (n_key[5]),
    .i_n_6   (n_key[6]),
    .i_n_7   (n_key[7]),
    .i_n_8   (n_key[8]),
    .i_n_9   (n_key[9]),
    .i_ready (i_ready),
    .o_a     (o_a),
    .o_b     (o_b),
    .o_c     (o_c),
    .o_d     (o_d),
    .o_valid (o_valid),
    .o_multi (o_multi)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  function automatic logic [9:0] key_mask(input int k);
    logic [9:0] m;
    m = '1;
    m[k] = 1'b0;
    return m;
  endfunction

  // Press from IDLE with a stable pattern: o_valid must stay low for five
  // edges and rise on the sixth with the expected code and multi flag.
  task automatic press(input string tag, input logic [9:0] keys,
                       input logic [3:0] exp_code, input logic exp_multi);
    n_key = keys;
    for (int i = 0; i < 5; i++) begin
      tick();
      check({tag, "_early"}, o_valid, 1'b0);
    end
    tick();
    check({tag, "_valid"}, o_valid, 1'b1);
    check({tag, "_code"}, code, exp_code);
    check({tag, "_multi"}, o_multi, exp_multi);
  endtask

  task automatic handshake_and_release(input string tag);
    i_ready = 1'b1;
    tick();
    check({tag, "_hs"}, o_valid, 1'b0);
    i_ready = 1'b0;
    n_key   = '1;
    tick(10);
  endtask

  initial begin
    int vcnt;
    logic saw_valid;

    i_n_rst = 1'b1;
    n_key   = '1;
    i_ready = 1'b0;

    // Reset asserted mid-clock, outputs clear without waiting for an edge.
    #3 i_n_rst = 1'b0;
    #1;
    check("rst_valid", o_valid, 1'b0);
    check("rst_code", code, 4'd0);
    check("rst_multi", o_multi, 1'b0);
    tick(2);
    #2 i_n_rst = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_valid) saw_valid = 1'b1;
    end
    check("idle_no_valid", saw_valid, 1'b0);

    // Single press of key 7, held while the consumer stalls.
    press("k7", key_mask(7), 4'd7, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("k7_hold_valid", o_valid, 1'b1);
      check("k7_hold_code", code, 4'd7);
    end
    handshake_and_release("k7");

    // Bounce on key 3: low 3, high 1, low 2, then released.
    saw_valid = 1'b0;
    n_key = key_mask(3);
    for (int i = 0; i < 3; i++) begin tick(); if (o_valid) saw_valid = 1'b1; end
    n_key = '1;
    tick(); if (o_valid) saw_valid = 1'b1;
    n_key = key_mask(3);
    for (int i = 0; i < 2; i++) begin tick(); if (o_valid) saw_valid = 1'b1; end
    n_key = '1;
    for (int i = 0; i < 12; i++) begin tick(); if (o_valid) saw_valid = 1'b1; end
    check("bounce_no_valid", saw_valid, 1'b0);
    press("k3", key_mask(3), 4'd3, 1'b0);
    handshake_and_release("k3");

    // Keys 3 and 9 together: 9 wins and multi is flagged.
    press("k39", key_mask(3) & key_mask(9), 4'd9, 1'b1);
    handshake_and_release("k39");
    press("k0", key_mask(0), 4'd0, 1'b0);
    handshake_and_release("k0");

    // Ready held high with key 5 held: exactly one single-cycle pulse.
    i_ready = 1'b1;
    n_key = key_mask(5);
    vcnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (o_valid) begin
        vcnt++;
        check("k5_code", code, 4'd5);
      end
    end
    check("k5_one_pulse", vcnt[7:0], 8'd1);

    // Three idle cycles are not enough to re-arm.
    n_key = '1;
    tick(3);
    n_key = key_mask(5);
    vcnt = 0;
    for (int i = 0; i < 30; i++) begin tick(); if (o_valid) vcnt++; end
    check("k5_short_release", vcnt[7:0], 8'd0);

    // Four idle cycles re-arm; the next press yields a second code.
    n_key = '1;
    tick(4);
    n_key = key_mask(5);
    vcnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (o_valid) begin
        vcnt++;
        check("k5_second_code", code, 4'd5);
      end
    end
    check("k5_rearmed", vcnt[7:0], 8'd1);
    i_ready = 1'b0;
    n_key = '1;
    tick(10);

    // Reset while presenting key 2; key stays held through reset.
    press("k2", key_mask(2), 4'd2, 1'b0);
    #2 i_n_rst = 1'b0;
    #1;
    check("k2_rst_valid", o_valid, 1'b0);
    check("k2_rst_code", code, 4'd0);
    #2 i_n_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("k2_re_early", o_valid, 1'b0);
    end
    tick();
    check("k2_re_valid", o_valid, 1'b1);
    check("k2_re_code", code, 4'd2);
    handshake_and_release("k2_re");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
